div_request_sequencer: RTL
==========================

DIV_REQUEST_SEQUENCER -- requirements
Module: div_request_sequencer

Interface
REQ-001 SHALL have parameters: WIDTH, 32, operand width; OUT_SIZE, 20, quotient width; TIMEOUT, 48, max cycles waiting for divider response.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: clk_in input 1 system clock; rst_n_in input 1 async active-low reset.
REQ-003 SHALL have client A request ports: a_valid_in input 1; a_dividend_in input WIDTH signed; a_divisor_in input WIDTH signed; a_ready_out output 1.
REQ-004 SHALL have client A response ports: a_quotient_out output OUT_SIZE; a_valid_out output 1 (one-cycle pulse); a_error_out output 1.
REQ-005 SHALL have client B ports b_valid_in, b_dividend_in, b_divisor_in, b_ready_out, b_quotient_out, b_valid_out, b_error_out, identical to client A.
REQ-006 SHALL have divider-side ports: div_dividend_out output WIDTH; div_divisor_out output WIDTH; div_valid_out output 1; div_busy_in input 1; div_quotient_in input OUT_SIZE; div_valid_in input 1.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND; exactly one request outstanding at a time.
REQ-008 IDLE: a_ready_out/b_ready_out combinational; at most one high; only the granted client's ready is high; both low outside IDLE.
REQ-009 Arbitration SHALL be round-robin: both valid -> grant client not served last; one valid -> grant it; after reset, A has priority.
REQ-010 Accept = valid & ready on a rising edge: SHALL latch dividend, divisor, client id; go to ISSUE if divisor != 0, else RESPOND with error.
REQ-011 ISSUE: div_valid_out SHALL be high for exactly one cycle, only when div_busy_in is low; while div_busy_in is high stay in ISSUE with div_valid_out low.
REQ-012 div_dividend_out/div_divisor_out SHALL hold the latched operands from ISSUE until leaving WAIT.
REQ-013 After the div_valid_out cycle, go to WAIT and clear a wait counter; the counter increments each WAIT cycle.
REQ-014 WAIT: div_valid_in high -> capture div_quotient_in, error=0, go to RESPOND.
REQ-015 WAIT: counter reaching TIMEOUT with no div_valid_in -> quotient 0, error=1, go to RESPOND.
REQ-016 If div_valid_in and timeout coincide, SHALL take the div_valid_in result (no error).
REQ-017 div_valid_in outside WAIT SHALL be ignored; no response generated.
REQ-018 Divide-by-zero (REQ-010) SHALL respond with quotient all ones, error=1; divider is never issued.
REQ-019 RESPOND: for exactly one cycle, owning client's x_valid_out=1, x_quotient_out and x_error_out valid; other client's valid stays 0; then IDLE and record last-served client.
REQ-020 x_quotient_out/x_error_out SHALL hold their value until that client's next response.
REQ-021 Nominal latency, accept edge to response pulse, with an idle divider: 1 (ISSUE) + divider latency (34) + 1 = 36 cycles.
REQ-022 A client deasserting valid before ready SHALL simply not be accepted; no partial state retained.

Reset
REQ-023 rst_n_in low SHALL immediately, without a clock edge, force IDLE, all outputs 0, wait counter 0, last-served = B (so A wins first tie).
REQ-024 Reset mid-WAIT SHALL drop the outstanding request silently; a div_valid_in arriving after reset release SHALL be ignored (REQ-017).
REQ-025 Reset deassertion SHALL be synchronised to clk_in before leaving IDLE behaviour.

Verification
REQ-026 A: 100/7 accepted, divider model returns 14 after 34 cycles -> a_valid_out pulse 36 cycles after accept, a_quotient_out=14, a_error_out=0, b_valid_out never high.
REQ-027 A and B both valid same cycle from reset -> A served first, B accepted in IDLE after A's RESPOND; B result on b_*; repeat -> order alternates B, A.
REQ-028 B: 5/0 -> no div_valid_out pulse; b_valid_out 2 cycles after accept with b_quotient_out=all ones, b_error_out=1.
REQ-029 Divider model never responds -> error response TIMEOUT+2 cycles after ISSUE, quotient 0, error 1; late div_valid_in afterward -> no response.
REQ-030 div_busy_in held high 10 cycles during ISSUE -> div_valid_out stays low, then single pulse when busy drops, operands stable throughout.
REQ-031 rst_n_in pulsed low mid-WAIT between clock edges -> outputs 0 immediately; subsequent div_valid_in produces no response; new A request served normally.

Source files
------------

// File: rtl/div_request_sequencer.sv
// Two-client front end for a shared iterative divider: round-robin arbitration,
// one request in flight, divide-by-zero short-circuit and divider response timeout.
module div_request_sequencer #(
    parameter int WIDTH    = 32,
    parameter int OUT_SIZE = 20,
    parameter int TIMEOUT  = 48
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    // client A
    input  logic                       a_valid_in,
    input  logic signed [WIDTH-1:0]    a_dividend_in,
    input  logic signed [WIDTH-1:0]    a_divisor_in,
    output logic                       a_ready_out,
    output logic [OUT_SIZE-1:0]        a_quotient_out,
    output logic                       a_valid_out,
    output logic                       a_error_out,
    // client B
    input  logic                       b_valid_in,
    input  logic signed [WIDTH-1:0]    b_dividend_in,
    input  logic signed [WIDTH-1:0]    b_divisor_in,
    output logic                       b_ready_out,
    output logic [OUT_SIZE-1:0]        b_quotient_out,
    output logic                       b_valid_out,
    output logic                       b_error_out,
    // divider side
    output logic [WIDTH-1:0]           div_dividend_out,
    output logic [WIDTH-1:0]           div_divisor_out,
    output logic                       div_valid_out,
    input  logic                       div_busy_in,
    input  logic [OUT_SIZE-1:0]        div_quotient_in,
    input  logic                       div_valid_in
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]          state;
    logic [1:0]          rst_sync;
    logic                run;
    logic                owner;      // 0 = A, 1 = B
    logic                last_b;     // last served client was B
    logic [CW-1:0]       wait_cnt;
    logic [OUT_SIZE-1:0] res_q;
    logic                res_err;
    logic                grant_a;
    logic                grant_b;
    logic [WIDTH-1:0]    sel_dividend;
    logic [WIDTH-1:0]    sel_divisor;

    // Deassertion of the async reset is retimed before requests are granted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == S_IDLE && run) begin
            if (a_valid_in && (!b_valid_in || last_b)) begin
                grant_a = 1'b1;
            end else if (b_valid_in) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready_out   = grant_a;
    assign b_ready_out   = grant_b;
    assign sel_dividend  = grant_b ? b_dividend_in : a_dividend_in;
    assign sel_divisor   = grant_b ? b_divisor_in  : a_divisor_in;
    assign div_valid_out = (state == S_ISSUE) && !div_busy_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= S_IDLE;
            owner            <= 1'b0;
            last_b           <= 1'b1;
            wait_cnt         <= '0;
            res_q            <= '0;
            res_err          <= 1'b0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            a_quotient_out   <= '0;
            a_valid_out      <= 1'b0;
            a_error_out      <= 1'b0;
            b_quotient_out   <= '0;
            b_valid_out      <= 1'b0;
            b_error_out      <= 1'b0;
        end else begin
            a_valid_out <= 1'b0;
            b_valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_a || grant_b) begin
                        owner            <= grant_b;
                        div_dividend_out <= sel_dividend;
                        div_divisor_out  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            res_q   <= '1;
                            res_err <= 1'b1;
                            state   <= S_RESPOND;
                        end else begin
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!div_busy_in) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A divider result on the timeout cycle still wins.
                    if (div_valid_in) begin
                        res_q   <= div_quotient_in;
                        res_err <= 1'b0;
                        state   <= S_RESPOND;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        res_q   <= '0;
                        res_err <= 1'b1;
                        state   <= S_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_RESPOND: begin
                    // Response outputs are registered: the pulse appears the cycle after RESPOND.
                    if (owner) begin
                        b_valid_out    <= 1'b1;
                        b_quotient_out <= res_q;
                        b_error_out    <= res_err;
                    end else begin
                        a_valid_out    <= 1'b1;
                        a_quotient_out <= res_q;
                        a_error_out    <= res_err;
                    end
                    last_b <= owner;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
